// File: rtl/mux_sel_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the 4:1 selector sequencer.
package sel_seq_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  function automatic logic [NCH-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    logic [NCH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Request/ack and selector-control bundle between the sequencer (master) and
// the selector/consumer side (slave).
interface mux_sel_sequencer_if
  import sel_seq_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic [NCH-1:0]       req;
  logic                 ack;
  logic                 sel1;
  logic                 sel0;
  logic [NCH-1:0]       grant;
  logic                 out_valid;
  logic                 busy;
  logic [NCH*CNT_W-1:0] grant_cnt;

  modport master (
    input  req, ack,
    output sel1, sel0, grant, out_valid, busy, grant_cnt
  );

  modport slave (
    output req, ack,
    input  sel1, sel0, grant, out_valid, busy, grant_cnt
  );

endinterface

// File: rtl/mux_sel_sequencer_rr_pick.sv
// Combinational round-robin picker: nearest requesting channel after 'last'.
module rr_pick
  import sel_seq_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    for (int off = NCH; off >= 1; off--) begin
      cand = last + SEL_W'(off);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer for the 4:1 gate-level selector with settle delay.
// Optional per-channel grant statistics are built when SEL_SEQ_STATS_EN is defined.
module mux_sel_sequencer
  import sel_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 8
)(
  input  logic                clk,
  input  logic                rst,
  mux_sel_sequencer_if.master bus
);

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_SETTLE = S_SETTLE;
  localparam logic [1:0] ST_HOLD   = S_HOLD;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] sel;
  logic [NCH-1:0]   grant;
  logic             out_valid;
  logic             busy;

  logic             take;
  logic [SEL_W-1:0] pick_last;
  logic             found;
  logic [SEL_W-1:0] pick_idx;

  // On the ack edge the pointer update must already steer the next search.
  assign take      = (state == ST_HOLD) && bus.ack;
  assign pick_last = take ? sel : last;

  rr_pick u_pick (
    .req   (bus.req),
    .last  (pick_last),
    .found (found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last      <= SEL_W'(NCH - 1);
      sel       <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            sel   <= pick_idx;
            grant <= idx2onehot(pick_idx);
            cnt   <= SETTLE_LOAD;
            busy  <= 1'b1;
            state <= ST_SETTLE;
          end else begin
            grant <= '0;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (bus.ack) begin
            last      <= sel;
            out_valid <= 1'b0;
            if (found) begin
              sel   <= pick_idx;
              grant <= idx2onehot(pick_idx);
              cnt   <= SETTLE_LOAD;
              state <= ST_SETTLE;
            end else begin
              grant <= '0;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          grant     <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel1      = sel[1];
  assign bus.sel0      = sel[0];
  assign bus.grant     = grant;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;

`ifdef SEL_SEQ_STATS_EN
  logic [CNT_W-1:0] stat [NCH];

  // Saturating per-channel counters, bumped on each accepted ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) stat[i] <= '0;
    end else if (take) begin
      for (int i = 0; i < NCH; i++) begin
        if (grant[i] && (stat[i] != '1)) stat[i] <= stat[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_stat
    assign bus.grant_cnt[g*CNT_W +: CNT_W] = stat[g];
  end
`else
  assign bus.grant_cnt = '0;
`endif

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream control stage for the 4:1 gate-level selector. Drives its sel1/sel0 inputs and tells the consumer when the selector output is stable.
- Picks among requesting channels in0..in3 round-robin. Holds the selection for a programmable settle time to cover gate propagation (not + two and levels).
- Asserts out_valid only after the settle time, then holds until the consumer acknowledges.

Parameters:
- SETTLE_CYC, 3: clock cycles between a select change and out_valid; legal range 1..15.
- CNT_W, 8: width of each per-channel grant counter (optional feature only).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; bit i = channel in<i> has data.
- ack  input  1  consumer has sampled the selector output; honoured only while out_valid=1.
- sel1  output  1  select MSB to the selector.
- sel0  output  1  select LSB to the selector.
- grant  output  4  one-hot copy of the current selection; 0 when idle.
- out_valid  output  1  selector output is settled and may be sampled.
- busy  output  1  high in SETTLE or HOLD.
- grant_cnt  output  4*CNT_W  per-channel grant counters, channel 0 in the LSBs (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high on clk.
  - sel1=0, sel0=0, grant=0, out_valid=0, busy=0.
  - last pointer=3, so the first search starts at channel 0.
  - Settle counter=0, state=IDLE, grant_cnt=0.
  - Reset asserted mid-operation aborts at the next edge. No ack is needed.
- All outputs are registered. No combinational path from req or ack to any output.
- States: IDLE, SETTLE, HOLD.
- Round-robin pick:
  - Search channels (last+1) mod 4, (last+2) mod 4, ... with wrap-around.
  - The first channel with req set wins; req=0000 means no pick.
- IDLE:
  - If a pick exists at edge N: at N+1 {sel1,sel0}=winner index, grant=one-hot, state=SETTLE, counter=SETTLE_CYC-1.
  - Otherwise stay in IDLE with grant=0.
  - sel1/sel0 keep their last value while idle; no glitching back to 00.
- SETTLE:
  - Decrement the counter each cycle.
  - When counter=0 and still in SETTLE: next edge enters HOLD with out_valid=1.
  - out_valid therefore rises exactly SETTLE_CYC cycles after sel changes.
- HOLD: out_valid=1; sel and grant stable until ack.
- ack=1 in HOLD at edge M:
  - last pointer=current sel; out_valid=0 at M+1.
  - If the pick, using the updated pointer and req at M, exists: new sel/grant at M+1, state=SETTLE.
  - Otherwise state=IDLE and grant=0 at M+1.
- ack while out_valid=0 is ignored.
- req is sampled only in IDLE or on the ack edge. Dropping req[sel] during SETTLE/HOLD does not abort.
- Simultaneous req changes and ack are resolved against the req value at the ack edge.
- Minimum spacing between two valid samples is SETTLE_CYC+1 cycles.

Optional Feature:
- Macro: SEL_SEQ_STATS_EN.
- Defined:
  - grant_cnt[i*CNT_W +: CNT_W] increments on each ack edge while channel i is granted.
  - Saturates at all-ones and never wraps.
  - Cleared by rst.
- Undefined: the grant_cnt port still exists for a stable interface, is tied to 0, and no counter flops are built.

Decomposition:
- Package sel_seq_pkg holds:
  - NCH=4 and SEL_W=2.
  - State enum {S_IDLE, S_SETTLE, S_HOLD}.
  - An idx-to-onehot function.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req[3:0], last[1:0].
  - Outputs: found, idx[1:0].
- FSM, settle counter and stats live in the top module.

Test Plan (SETTLE_CYC=3):
- Reset then req=0000 for 10 cycles -> sel=00, grant=0000, out_valid=0, busy=0 throughout.
- req=0100 at edge 0 -> edge 1: sel=10, grant=0100, busy=1; edge 4: out_valid=1; ack at edge 6 -> edge 7: out_valid=0, state IDLE, grant=0000.
- req=1111 held with ack pulsed on every valid cycle -> grant order 0001, 0010, 0100, 1000, 0001; out_valid pulses are 4 cycles apart.
- Last grant ch3, req=1001 at ack -> next grant is ch0 (wrap-around), sel=00.
- rst asserted during SETTLE with counter=1 -> next edge: all outputs at reset values; out_valid never rises.
- SEL_SEQ_STATS_EN defined, CNT_W=2, ch1 granted and acked 5 times -> grant_cnt[3:2]=3 (saturated), other fields 0. Undefined -> grant_cnt=0.
